// File: rtl/act_lut_pipe.sv
// Run-time loadable activation LUT with a 2-stage valid/ready lookup pipeline.
// Define LUT_SYM_EN to store only the x>=0 half and rebuild x<0 as ONE - f(-x).
module act_lut_pipe #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_done_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

`ifdef LUT_SYM_EN
  localparam int IDX_W = ADDR_W - 1;
`else
  localparam int IDX_W = ADDR_W;
`endif
  localparam int TD = 1 << IDX_W;

  if (FRAC_W >= DATA_W) begin : g_bad_frac
    $error("act_lut_pipe: FRAC_W must be smaller than DATA_W");
  end

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   wptr_q;
  logic               load_done_q;
  logic               s1_valid_q, out_valid_q;
  logic [DATA_W-1:0]  rd_q, out_data_q, post;
  logic [IDX_W-1:0]   rd_idx;
  logic               adv, accept, wr_en;
  logic [DATA_W-1:0]  mem [TD];

  assign adv        = !out_valid_q | out_ready_i;
  assign in_ready_o = (state_q == S_RUN) & adv;
  assign accept     = in_valid_i & in_ready_o;
  assign wr_en      = (state_q == S_LOAD) & load_valid_i & !load_start_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      wptr_q      <= '0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        S_EMPTY: if (load_start_i) begin
          state_q <= S_LOAD;
          wptr_q  <= '0;
        end
        S_LOAD: begin
          if (load_start_i) wptr_q <= '0;
          else if (load_valid_i) begin
            wptr_q <= wptr_q + 1'b1;
            if (&wptr_q) begin
              state_q     <= S_RUN;
              load_done_q <= 1'b1;
            end
          end
        end
        S_RUN: if (load_start_i) state_q <= S_DRAIN;
        S_DRAIN: if (!s1_valid_q && !out_valid_q) begin
          state_q <= S_LOAD;
          wptr_q  <= '0;
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  // Writes only happen in LOAD and reads only in RUN, so one port suffices.
  always_ff @(posedge clk) begin
    if (wr_en)                mem[wptr_q] <= load_data_i;
    else if (accept && adv)   rd_q        <= mem[rd_idx];
  end

`ifdef LUT_SYM_EN
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
  logic [ADDR_W-1:0] addr_neg;
  logic              in_neg, in_mn, s1_neg_q, s1_mn_q;

  assign addr_neg = -in_addr_i;
  assign in_neg   = in_addr_i[ADDR_W-1];
  assign in_mn    = in_neg & ~|in_addr_i[ADDR_W-2:0];
  assign rd_idx   = in_neg ? addr_neg[IDX_W-1:0] : in_addr_i[IDX_W-1:0];
  assign post     = s1_mn_q ? '0 : (s1_neg_q ? ONE - rd_q : rd_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_neg_q <= 1'b0;
      s1_mn_q  <= 1'b0;
    end else if (adv) begin
      s1_neg_q <= in_neg;
      s1_mn_q  <= in_mn;
    end
  end
`else
  assign rd_idx = in_addr_i;
  assign post   = rd_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q  <= accept;
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) out_data_q <= post;
    end
  end

  assign load_done_o = load_done_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_act_lut_pipe.sv
// Directed bench for act_lut_pipe: reset, load, streaming, backpressure, reload, reset mid-load.
module tb_act_lut_pipe;
`ifdef LUT_SYM_EN
  localparam int TD = 128;
`else
  localparam int TD = 256;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_done;
  logic [15:0] load_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_addr;
  logic [15:0] out_data;

  int total  = 0;
  int passed = 0;

  act_lut_pipe #(.ADDR_W(8), .DATA_W(16), .FRAC_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(load_start), .load_valid_i(load_valid), .load_data_i(load_data),
    .load_done_o(load_done),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int mode, input int i);
    case (mode)
      0:       return 16'(i * 3);
      1:       return 16'(32'hFFFF - i);
      2:       return 16'(i * 5);
      default: return 16'(32'h800 + i * 8);
    endcase
  endfunction

  task automatic load(input int mode, input int n);
    int pulses = 0;
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = pat(mode, i);
      if (load_done) pulses++;
      step;
    end
    load_valid = 1'b0;
    #1;
    if (n == TD) begin
      chk("load_done_early", pulses, 0);
      chk("load_done_pulse", load_done, 1);
      step;
      chk("load_done_once", load_done, 0);
    end
  endtask

  task automatic lookup(input string tag, input logic [7:0] a, input logic [15:0] exp);
    int cyc = 0;
    in_valid = 1'b1;
    in_addr  = a;
    #1;
    while (!in_ready && cyc < 10) begin step; cyc++; end
    chk({tag, "_ready"}, in_ready, 1);
    step;
    in_valid = 1'b0;
    cyc = 0;
    #1;
    while (!out_valid && cyc < 10) begin step; cyc++; end
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_data, exp);
    step;
  endtask

  initial begin
    int sent, got, pulses;
    logic hold_chk;
    logic [15:0] held;
    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    in_valid = 1'b1; in_addr = 8'h00; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_load_done", load_done, 0);
    step;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step;
      chk("empty_in_ready", in_ready, 0);
      chk("empty_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

`ifdef LUT_SYM_EN
    load(3, TD);
    lookup("sym_pos5", 8'h05, 16'h0828);
    lookup("sym_neg5", 8'hFB, 16'h07D8);
    lookup("sym_mostneg", 8'h80, 16'h0000);
    lookup("sym_pos127", 8'h7F, 16'h0BF8);
    lookup("sym_neg127", 8'h81, 16'h0408);
    lookup("sym_zero", 8'h00, 16'h0800);
`else
    load(0, TD);
    // Back-to-back stream: first result two edges after acceptance.
    in_valid = 1'b1; in_addr = 8'h2F; #1;
    chk("run_ready", in_ready, 1);
    step;
    in_addr = 8'h56; #1;
    chk("lat_not_yet", out_valid, 0);
    step;
    in_addr = 8'h49; #1;
    chk("s0_vld", out_valid, 1);
    chk("s0_data", out_data, 16'h008D);
    step;
    in_valid = 1'b0; #1;
    chk("s1_vld", out_valid, 1);
    chk("s1_data", out_data, 16'h0102);
    step;
    chk("s2_vld", out_valid, 1);
    chk("s2_data", out_data, 16'h00DB);
    step;
    chk("s_idle", out_valid, 0);
    lookup("wrap_ff", 8'hFF, 16'h02FD);

    sent = 0; got = 0; hold_chk = 1'b0; held = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      in_valid  = (sent < 5);
      in_addr   = 8'(sent + 1);
      out_ready = !(c >= 3 && c < 6);
      #1;
      if (hold_chk) chk("bp_hold", out_data, held);
      hold_chk = out_valid && !out_ready;
      held     = out_data;
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, 16'(3 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      step;
    end
    chk("bp_count", got, 5);
    in_valid = 1'b0; out_ready = 1'b1;
    step;

    // Reload requested with two lookups still in the pipe.
    in_valid = 1'b1; in_addr = 8'h10;
    step;
    in_addr = 8'h11;
    step;
    in_valid = 1'b0; load_start = 1'b1; #1;
    chk("drain_old0", out_data, 16'h0030);
    step;
    load_start = 1'b0; #1;
    chk("drain_ready", in_ready, 0);
    chk("drain_vld", out_valid, 1);
    chk("drain_old1", out_data, 16'h0033);
    step;
    chk("drain_empty", out_valid, 0);
    step;
    load(1, TD);
    lookup("reload_10", 8'h10, 16'hFFEF);

    load(2, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", in_ready, 0);
    chk("rstmid_done", load_done, 0);
    chk("rstmid_vld", out_valid, 0);
    step;
    rst_n = 1'b1;
    pulses = 0;
    in_valid = 1'b1; in_addr = 8'h2F;
    for (int i = 0; i < 200; i++) begin
      load_valid = 1'b1; load_data = 16'hAAAA;
      step;
      if (load_done || in_ready) pulses++;
    end
    load_valid = 1'b0; in_valid = 1'b0;
    chk("rstmid_no_done", pulses, 0);
    load(2, TD);
    lookup("fresh_2f", 8'h2F, 16'h00EB);
    lookup("fresh_ff", 8'hFF, 16'h04FB);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
